condlogic: RTL
==============

# condlogic

Conditional-execution unit for the multicycle ARM datapath. It sits directly downstream of the instruction decoder/main FSM and consumes its FlagW, PCS, NextPC, RegW and MemW outputs. It holds the NZCV flags register, evaluates the instruction's condition field, and gates the decoder's write strobes into the architectural PCWrite, RegWrite and MemWrite enables. It also registers the condition result so that later FSM states act on the outcome evaluated before those states.

## Interface

- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- Cond  input  4  Instr[31:28], the condition field; stable from Decode until the next fetch.
- ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle.
- FlagW  input  2  from decode; [1] requests an N,Z update, [0] requests a C,V update.
- PCS  input  1  from decode; the instruction writes the PC (branch, or Rd = R15).
- NextPC  input  1  from the main FSM; unconditional PC update in the Fetch state.
- RegW  input  1  from the main FSM; register-file write request.
- MemW  input  1  from the main FSM; memory write request.
- PCWrite  output  1  PC register enable.
- RegWrite  output  1  register-file write enable.
- MemWrite  output  1  data-memory write enable.
- Flags  output  4  current {N,Z,C,V}; for debug and testbench observation.
- CondEx  output  1  combinational condition result; for debug and testbench observation.

## Operation

- Flags register: 4 bits, {N,Z,C,V}, reset to 4'b0000.
- Combinational flag-write enable: FlagWrite[1:0] = FlagW & {2{CondEx}}.
  - FlagWrite[1]: Flags[3:2] <= ALUFlags[3:2] on the next edge.
  - FlagWrite[0]: Flags[1:0] <= ALUFlags[1:0] on the next edge.
  - The two halves are independent; an unwritten half holds its value.
- CondEx is combinational from Cond and the current registered Flags, never from ALUFlags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 0 (reserved; the instruction executes as a no-op, but fetch continues through NextPC).
- CondExDelayed: 1-bit register loaded with CondEx on every rising edge; reset to 0.
- Output gating (combinational):
  - PCWrite = (PCS & CondExDelayed) | NextPC
  - RegWrite = RegW & CondExDelayed
  - MemWrite = MemW & CondExDelayed
- NextPC is never gated; the fetch PC increment always occurs.

## Timing

- Reset asserted, asynchronously:
  - Flags = 0000 and CondExDelayed = 0.
  - PCWrite = NextPC; RegWrite = 0; MemWrite = 0.
  - CondEx then reflects Cond evaluated against flags 0000.
- Latency:
  - FlagW to Flags visible: 1 cycle (next edge).
  - CondEx to gated strobes: 1 cycle through CondExDelayed.
- Intended FSM usage: CondEx is captured in Decode and valid in Execute and all later states. A MemWrite, ALUWB or Branch state therefore sees the condition as it was before the edge that ends Execute.
- Flag update and CondExDelayed capture on the same edge: CondExDelayed takes the pre-update CondEx. Required for ADDSEQ-style instructions, which must not re-evaluate their own condition against their own new flags.
- FlagW asserted while CondEx = 0: no flag bit changes.
- FlagW = 2'b11: all four flags load simultaneously.
- Reset deasserted mid-instruction: the first post-reset strobes are gated by CondExDelayed = 0 until one edge has passed.

## Test plan

- Reset:
  - Stimulus: reset = 1, NextPC = 1, RegW = 1, MemW = 1, PCS = 1.
  - Required: Flags = 0000, PCWrite = 1, RegWrite = 0, MemWrite = 0.
  - Stimulus: drop NextPC.
  - Required: PCWrite = 0.
- Flag halves:
  - Stimulus: Cond = 1110, FlagW = 10, ALUFlags = 1111, one edge.
  - Required: Flags = 1100.
  - Stimulus: then FlagW = 01, ALUFlags = 0001.
  - Required: Flags = 1101.
- Condition sweep:
  - Stimulus: for Flags in {0000, 0100, 1000, 0010, 1001, 0110}, drive every Cond 0000–1111.
  - Required: CondEx matches the table above; Cond = 1111 always gives 0.
- Gating:
  - Stimulus: Flags = 0000 (Z = 0), Cond = 0000 (EQ), edge, then RegW = 1, MemW = 1, PCS = 1.
  - Required: RegWrite = 0, MemWrite = 0, PCWrite = 0.
  - Stimulus: repeat with Flags = 0100.
  - Required: all three outputs = 1.
- Self-condition:
  - Stimulus: Flags = 0100, Cond = 0000, FlagW = 11, ALUFlags = 0000, one edge.
  - Required: Flags = 0000 and CondExDelayed = 1, so the following RegW = 1 gives RegWrite = 1.
- Async reset mid-stream:
  - Stimulus: Flags = 1111, CondExDelayed = 1, RegW = 1; pulse reset between clock edges.
  - Required: RegWrite drops to 0 and Flags = 0000 before the next edge.

Source files
------------

// File: rtl/condlogic.sv
// Conditional-execution unit: NZCV flags register, condition evaluation,
// and write-strobe gating driven by the condition registered one edge earlier.
module condlogic (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    logic [3:0] r_flags;
    logic       r_cond_ex_d;
    logic [1:0] w_flag_write;
    logic       w_cond_ex;
    logic       w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign w_flag_write = FlagW & {2{w_cond_ex}};

    // Condition is captured from the pre-update flags, so an instruction never
    // re-evaluates its own condition against the flags it is writing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags     <= '0;
            r_cond_ex_d <= 1'b0;
        end else begin
            if (w_flag_write[1]) r_flags[3:2] <= ALUFlags[3:2];
            if (w_flag_write[0]) r_flags[1:0] <= ALUFlags[1:0];
            r_cond_ex_d <= w_cond_ex;
        end
    end

    assign PCWrite  = (PCS & r_cond_ex_d) | NextPC;
    assign RegWrite = RegW & r_cond_ex_d;
    assign MemWrite = MemW & r_cond_ex_d;
    assign Flags    = r_flags;
    assign CondEx   = w_cond_ex;

endmodule
